// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//
// Contents:
//   IMEM_DEPTH       default instruction memory depth in 32-bit words
//   IMEM_ADDR_WIDTH  word-address width for IMEM_DEPTH
//   COUNT_WIDTH      width of the word count carried in the frame header
//   loader_state_t   loader FSM states
//   shift_in_byte    little-endian byte assembly step
package imem_loader_pkg;

   localparam int unsigned IMEM_DEPTH      = 256;
   localparam int unsigned IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH);
   localparam int unsigned COUNT_WIDTH     = 16;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

   // Bytes arrive least-significant first, so each new byte enters at the top
   // and after four bytes the first one has reached bits [7:0].
   function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                 input logic [7:0]  byte_in);
      return {byte_in, word[31:8]};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
//
// Signals:
//   rx_valid   stream source offers rx_data
//   rx_data    stream byte
//   rx_ready   loader accepts the byte this cycle
//   mem_we     imem write strobe, one cycle per word
//   mem_addr   imem word address
//   mem_wdata  imem write data
// Modports:
//   master  stream source / memory side (testbench or boot controller)
//   slave   the loader
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH
);

   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Byte-to-word assembler for the boot loader.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   byte_in     incoming stream byte
//   byte_en     byte_in is consumed this cycle
//   clear       restart assembly at byte 0 (wins over byte_en)
//   word_out    word formed by the held bytes plus byte_in
//   word_valid  byte_en on the 4th byte of a word; word_out is complete
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_en,
   input  logic        clear,
   output logic [31:0] word_out,
   output logic        word_valid
);

   logic [31:0] shift_q;
   logic [1:0]  byte_idx_q;

   // Combinational so the caller can register the word on the same edge that
   // accepts the 4th byte, giving a one-cycle write latency.
   assign word_out   = shift_in_byte(shift_q, byte_in);
   assign word_valid = byte_en && (byte_idx_q == 2'd3);

   always_ff @(posedge clk) begin
      if (!reset) begin
         shift_q    <= '0;
         byte_idx_q <= '0;
      end else if (clear) begin
         shift_q    <= '0;
         byte_idx_q <= '0;
      end else if (byte_en) begin
         shift_q    <= word_out;
         byte_idx_q <= byte_idx_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
//
// Receives a framed little-endian byte stream (16-bit word count, then the
// words), writes word k to imem word address k and keeps the core in reset
// until the image is complete.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   start      single-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   bus        imem_loader_if.slave: rx_valid/rx_data/rx_ready stream in,
//              mem_we/mem_addr/mem_wdata imem write port out
//   core_hold  keeps the core/PC in reset while high
//   done       load completed successfully (level)
//   error      load aborted (level)
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  frame carries a trailing XOR checksum of the data
//                            bytes; a mismatch ends in ERR.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   imem_loader_if.slave       bus,
   output logic               core_hold,
   output logic               done,
   output logic               error
);

   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

   loader_state_t          state_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [ADDR_WIDTH-1:0]  word_idx_q;
   logic                   mem_we_q;
   logic [ADDR_WIDTH-1:0]  mem_addr_q;
   logic [31:0]            mem_wdata_q;
   logic                   core_hold_q;
   logic                   done_q;
   logic                   error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]             csum_q;
`endif

   logic                   rx_ready;
   logic                   xfer;
   logic [COUNT_WIDTH-1:0] hdr_count;
   logic                   last_word;
   logic                   asm_en;
   logic                   asm_clear;
   logic [31:0]            word_out;
   logic                   word_valid;

   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         HDR0, HDR1, DATA: rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:             rx_ready = 1'b1;
`endif
         default:          rx_ready = 1'b0;
      endcase
   end

   assign xfer      = bus.rx_valid && rx_ready;
   assign hdr_count = {bus.rx_data, count_q[7:0]};
   // count_q >= 1 in DATA, so count_q - 1 cannot underflow here.
   assign last_word = (COUNT_WIDTH'(word_idx_q) == (count_q - 1'b1));
   assign asm_en    = xfer && (state_q == DATA);
   assign asm_clear = xfer && (state_q == HDR1);

   imem_loader_word_assembler u_word_assembler (
      .clk        (clk),
      .reset      (reset),
      .byte_in    (bus.rx_data),
      .byte_en    (asm_en),
      .clear      (asm_clear),
      .word_out   (word_out),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         word_idx_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         core_hold_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         // Write strobe is a single-cycle pulse; address and data hold.
         mem_we_q <= 1'b0;
         if (word_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= word_idx_q;
            mem_wdata_q <= word_out;
         end

         case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state_q     <= HDR0;
                  count_q     <= '0;
                  core_hold_q <= 1'b1;
                  done_q      <= 1'b0;
                  error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q      <= '0;
`endif
               end
            end

            HDR0: begin
               if (xfer) begin
                  count_q[7:0] <= bus.rx_data;
                  state_q      <= HDR1;
               end
            end

            HDR1: begin
               if (xfer) begin
                  count_q    <= hdr_count;
                  word_idx_q <= '0;
                  if (hdr_count == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_q     <= CSUM;
`else
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     core_hold_q <= 1'b0;
`endif
                  end else if (32'(hdr_count) > DEPTH) begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end

            DATA: begin
               if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ bus.rx_data;
`endif
                  if (word_valid) begin
                     // Leave word_idx_q alone on the last word so a full-depth
                     // image never wraps the address counter.
                     if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q     <= CSUM;
`else
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        core_hold_q <= 1'b0;
`endif
                     end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                     end
                  end
               end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (xfer) begin
                  if (bus.rx_data == csum_q) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     core_hold_q <= 1'b0;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rx_ready  = rx_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign core_hold     = core_hold_q;
   assign done          = done_q;
   assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader. Inputs change on the falling
// edge; outputs are sampled on the falling edge, the write monitor model is
// read #1 after a falling edge.
module tb_imem_loader;

   localparam int unsigned DEPTH = 256;

   logic clk;
   logic reset;
   logic start;
   logic core_hold;
   logic done;
   logic error;

   imem_loader_if bus ();

   imem_loader #(
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bus       (bus),
      .core_hold (core_hold),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          wr_count = 0;
   logic [7:0]  last_addr = '0;
   logic [31:0] mem_model [DEPTH];
   logic [7:0]  tb_csum = '0;

   // Instruction memory model: records every write strobe.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         mem_model[bus.mem_addr] <= bus.mem_wdata;
         wr_count                <= wr_count + 1;
         last_addr               <= bus.mem_addr;
      end
   end

   task automatic fill_model(input logic [31:0] v);
      for (int i = 0; i < DEPTH; i++) mem_model[i] = v;
   endtask

   // Let the write monitor catch up, leave time at negedge + 1.
   task automatic settle();
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (bus.rx_ready !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.rx_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_byte: rx_ready=%b after %0d cycles, required 1 (byte %h)",
                  bus.rx_ready, n, b);
      end
      tb_csum = tb_csum ^ b;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_header(input logic [15:0] count);
      send_byte(count[7:0]);
      send_byte(count[15:8]);
      tb_csum = 8'h00;
   endtask

   task automatic end_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(tb_csum);
`endif
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      checks += 7;
      if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset rx_ready: got %b want 0", bus.rx_ready); end
      if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %b want 0", bus.mem_we); end
      if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset mem_addr: got %h want 00", bus.mem_addr); end
      if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_wdata: got %h want 0", bus.mem_wdata); end
      if (core_hold !== 1'b1) begin errors++; $display("FAIL reset core_hold: got %b want 1", core_hold); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
      if (error !== 1'b0) begin errors++; $display("FAIL reset error: got %b want 0", error); end
      reset = 1'b1;
   endtask

   task automatic test_basic();
      int w0;
      fill_model(32'hffff_ffff);
      w0 = wr_count;
      pulse_start();
      send_header(16'd2);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      checks += 3;
      if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL basic we0: got %b want 1", bus.mem_we); end
      if (bus.mem_addr !== 8'd0) begin errors++; $display("FAIL basic addr0: got %h want 00", bus.mem_addr); end
      if (bus.mem_wdata !== 32'h0000_0013) begin errors++; $display("FAIL basic data0: got %h want 00000013", bus.mem_wdata); end
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      checks += 3;
      if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL basic we1: got %b want 1", bus.mem_we); end
      if (bus.mem_addr !== 8'd1) begin errors++; $display("FAIL basic addr1: got %h want 01", bus.mem_addr); end
      if (bus.mem_wdata !== 32'h0010_0093) begin errors++; $display("FAIL basic data1: got %h want 00100093", bus.mem_wdata); end
      end_frame();
      checks += 3;
      if (done !== 1'b1) begin errors++; $display("FAIL basic done: got %b want 1", done); end
      if (core_hold !== 1'b0) begin errors++; $display("FAIL basic core_hold: got %b want 0", core_hold); end
      if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL basic rx_ready: got %b want 0", bus.rx_ready); end
      settle();
      checks += 3;
      if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL basic we_idle: got %b want 0", bus.mem_we); end
      if (wr_count - w0 !== 2) begin errors++; $display("FAIL basic writes: got %0d want 2", wr_count - w0); end
      // Fetch at pc=4 reads word 1.
      if (mem_model[4 >> 2] !== 32'h0010_0093) begin errors++; $display("FAIL basic fetch_pc4: got %h want 00100093", mem_model[1]); end
   endtask

   task automatic test_gaps();
      logic [7:0] frame [8];
      int w0;
      frame = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      fill_model(32'hffff_ffff);
      w0 = wr_count;
      pulse_start();
      send_header(16'd2);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         send_byte(frame[i]);
      end
      end_frame();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL gaps done: got %b want 1", done); end
      settle();
      checks += 3;
      if (wr_count - w0 !== 2) begin errors++; $display("FAIL gaps writes: got %0d want 2", wr_count - w0); end
      if (mem_model[0] !== 32'h0000_0013) begin errors++; $display("FAIL gaps word0: got %h want 00000013", mem_model[0]); end
      if (mem_model[1] !== 32'h0010_0093) begin errors++; $display("FAIL gaps word1: got %h want 00100093", mem_model[1]); end
   endtask

   task automatic test_boundary();
      int w0;
      fill_model(32'hffff_ffff);
      w0 = wr_count;
      pulse_start();
      send_header(16'd256);
      for (int k = 0; k < 256; k++) begin
         send_byte(8'(k)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      end
      checks += 3;
      if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL full we_last: got %b want 1", bus.mem_we); end
      if (bus.mem_addr !== 8'd255) begin errors++; $display("FAIL full addr_last: got %h want ff", bus.mem_addr); end
      if (bus.mem_wdata !== 32'd255) begin errors++; $display("FAIL full data_last: got %h want 000000ff", bus.mem_wdata); end
      end_frame();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL full done: got %b want 1", done); end
      settle();
      checks += 4;
      if (wr_count - w0 !== 256) begin errors++; $display("FAIL full writes: got %0d want 256", wr_count - w0); end
      if (last_addr !== 8'd255) begin errors++; $display("FAIL full last_addr: got %h want ff", last_addr); end
      if (mem_model[0] !== 32'd0) begin errors++; $display("FAIL full word0: got %h want 0", mem_model[0]); end
      if (mem_model[128] !== 32'd128) begin errors++; $display("FAIL full word128: got %h want 80", mem_model[128]); end

      // One word too many: rejected at the header.
      w0 = wr_count;
      pulse_start();
      send_header(16'd257);
      checks += 4;
      if (error !== 1'b1) begin errors++; $display("FAIL over error: got %b want 1", error); end
      if (core_hold !== 1'b1) begin errors++; $display("FAIL over core_hold: got %b want 1", core_hold); end
      if (done !== 1'b0) begin errors++; $display("FAIL over done: got %b want 0", done); end
      if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL over rx_ready: got %b want 0", bus.rx_ready); end
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h55;
      repeat (6) @(negedge clk);
      bus.rx_valid = 1'b0;
      settle();
      checks++;
      if (wr_count - w0 !== 0) begin errors++; $display("FAIL over writes: got %0d want 0", wr_count - w0); end
   endtask

   task automatic test_empty_restart();
      fill_model(32'hffff_ffff);
      @(negedge clk);
      pulse_start();
      send_header(16'd0);
      end_frame();
      checks += 2;
      if (done !== 1'b1) begin errors++; $display("FAIL empty done: got %b want 1", done); end
      if (core_hold !== 1'b0) begin errors++; $display("FAIL empty core_hold: got %b want 0", core_hold); end
      pulse_start();
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("FAIL restart done_drop: got %b want 0", done); end
      if (core_hold !== 1'b1) begin errors++; $display("FAIL restart core_hold: got %b want 1", core_hold); end
      send_header(16'd1);
      send_byte(8'hef); send_byte(8'hbe); send_byte(8'had); send_byte(8'hde);
      end_frame();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL restart done: got %b want 1", done); end
      settle();
      checks++;
      if (mem_model[0] !== 32'hdead_beef) begin errors++; $display("FAIL restart word0: got %h want deadbeef", mem_model[0]); end
   endtask

   task automatic test_reset_mid();
      int w0;
      @(negedge clk);
      pulse_start();
      send_header(16'd2);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checks += 5;
      if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL rstmid rx_ready: got %b want 0", bus.rx_ready); end
      if (core_hold !== 1'b1) begin errors++; $display("FAIL rstmid core_hold: got %b want 1", core_hold); end
      if (done !== 1'b0) begin errors++; $display("FAIL rstmid done: got %b want 0", done); end
      if (error !== 1'b0) begin errors++; $display("FAIL rstmid error: got %b want 0", error); end
      if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstmid mem_we: got %b want 0", bus.mem_we); end
      settle();
      w0 = wr_count;
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h07;
      repeat (6) @(negedge clk);
      bus.rx_valid = 1'b0;
      settle();
      checks++;
      if (wr_count - w0 !== 0) begin errors++; $display("FAIL rstmid writes: got %0d want 0", wr_count - w0); end
   endtask

   task automatic test_start_with_valid();
      fill_model(32'hffff_ffff);
      @(negedge clk);
      start        = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h05;
      checks++;
      if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL idle rx_ready: got %b want 0", bus.rx_ready); end
      @(negedge clk);
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      checks++;
      if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL hdr0 rx_ready: got %b want 1", bus.rx_ready); end
      send_header(16'd1);
      send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
      end_frame();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL startvalid done: got %b want 1", done); end
      settle();
      checks++;
      if (mem_model[0] !== 32'hddcc_bbaa) begin errors++; $display("FAIL startvalid word0: got %h want ddccbbaa", mem_model[0]); end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      int w0;
      @(negedge clk);
      pulse_start();
      send_header(16'd1);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h13);
      checks += 2;
      if (done !== 1'b1) begin errors++; $display("FAIL csum_ok done: got %b want 1", done); end
      if (error !== 1'b0) begin errors++; $display("FAIL csum_ok error: got %b want 0", error); end
      w0 = wr_count;
      pulse_start();
      send_header(16'd1);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h12);
      checks += 3;
      if (error !== 1'b1) begin errors++; $display("FAIL csum_bad error: got %b want 1", error); end
      if (core_hold !== 1'b1) begin errors++; $display("FAIL csum_bad core_hold: got %b want 1", core_hold); end
      if (done !== 1'b0) begin errors++; $display("FAIL csum_bad done: got %b want 0", done); end
      settle();
      checks++;
      if (wr_count - w0 !== 1) begin errors++; $display("FAIL csum_bad writes: got %0d want 1", wr_count - w0); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_boundary();
      test_empty_restart();
      test_reset_mid();
      test_start_with_valid();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Backstop against a hung handshake.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

endmodule
